// File: rtl/fifo_native2stream.sv
// Drains a non-FWFT native FIFO (1-cycle read latency) into an AXI-Stream master.
// A 2-entry skid buffer plus a pending-read flag gives full throughput without overflow.
module fifo_native2stream #(
   parameter int unsigned DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  empty,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [1:0]            buf_count
);

   logic [1:0]            count_q, count_d;
   logic                  rd_pend_q;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic                  pop;
   logic [1:0]            free;
   logic [1:0]            cnt_after_pop;

   always_comb begin
      pop           = (count_q != 2'd0) & m_axis_tready;
      // Slots left once this cycle's pop and the in-flight read are accounted for.
      free          = 2'd2 - count_q - {1'b0, rd_pend_q} + {1'b0, pop};
      rd_en         = !rst & !empty & (free != 2'd0);
      cnt_after_pop = count_q - {1'b0, pop};

      head_d = head_q;
      tail_d = tail_q;
      if (pop) begin
         head_d = tail_q;
      end
      if (rd_pend_q) begin
         if (cnt_after_pop == 2'd0) begin
            head_d = data_out;
         end else begin
            tail_d = data_out;
         end
      end
      count_d = cnt_after_pop + {1'b0, rd_pend_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 2'd0;
         rd_pend_q <= 1'b0;
         head_q    <= '0;
         tail_q    <= '0;
      end else begin
         count_q   <= count_d;
         rd_pend_q <= rd_en;
         head_q    <= head_d;
         tail_q    <= tail_d;
      end
   end

   assign m_axis_tvalid = (count_q != 2'd0);
   assign m_axis_tdata  = head_q;
   assign buf_count     = count_q;

endmodule

// File: tb/tb_fifo_native2stream.sv
// Bench for fifo_native2stream: queue-based FIFO model feeds the DUT, and a scoreboard
// checks the stream output order plus the AXI hold and no-read-while-empty rules.
module tb_fifo_native2stream;

   localparam int unsigned DW = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          empty = 1'b1;
   logic          rd_en;
   logic [DW-1:0] data_out = '0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic [DW-1:0] m_axis_tdata;
   logic [1:0]    buf_count;

   fifo_native2stream #(.DATA_WIDTH(DW)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .empty        (empty),
      .rd_en        (rd_en),
      .data_out     (data_out),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .buf_count    (buf_count)
   );

   always #5 clk = ~clk;

   int unsigned   n_cmp = 0;
   int unsigned   n_bad = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic          gap = 1'b0;

   logic          s_rd_en, s_empty, s_tvalid, s_beat;
   logic [DW-1:0] s_tdata;
   logic [1:0]    s_cnt;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
   endtask

   // One clock: settle inputs, sample/check mid-cycle, then model the FIFO read latency.
   task automatic tick();
      logic [DW-1:0] want;
      empty = gap | (fifo_q.size() == 0);
      #1;
      s_rd_en  = rd_en;
      s_empty  = empty;
      s_tvalid = m_axis_tvalid;
      s_tdata  = m_axis_tdata;
      s_cnt    = buf_count;
      s_beat   = m_axis_tvalid & m_axis_tready & !rst;
      check_eq("rd_en_while_empty", DW'(s_rd_en & s_empty), '0);
      if (!rst && prev_hold) begin
         check_eq("hold_tvalid", DW'(s_tvalid), DW'(1));
         check_eq("hold_tdata", s_tdata, prev_data);
      end
      if (s_beat) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", s_tdata, '1);
         end else begin
            want = exp_q.pop_front();
            check_eq("beat_data", s_tdata, want);
         end
      end
      prev_hold = !rst & s_tvalid & !m_axis_tready;
      prev_data = s_tdata;
      @(posedge clk);
      #1;
      if (s_rd_en && fifo_q.size() != 0) data_out = fifo_q.pop_front();
      @(negedge clk);
   endtask

   initial begin
      int first_rd, first_beat, last_beat, rd_cnt, nb, pushed, rx, cyc;
      logic [DW-1:0] w;

      // Reset with a non-empty FIFO: nothing may be read or presented.
      @(negedge clk);
      rst = 1'b1;
      m_axis_tready = 1'b1;
      push(DW'(8'hA5));
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rst_rd_en", DW'(s_rd_en), '0);
         check_eq("rst_tvalid", DW'(s_tvalid), '0);
         check_eq("rst_tdata", s_tdata, '0);
         check_eq("rst_cnt", DW'(s_cnt), '0);
      end

      // Single word: rd_en at T, beat at T+2 only.
      rst = 1'b0;
      tick();
      check_eq("single_rd_T", DW'(s_rd_en), DW'(1));
      check_eq("single_tvalid_T", DW'(s_tvalid), '0);
      tick();
      check_eq("single_rd_T1", DW'(s_rd_en), '0);
      check_eq("single_tvalid_T1", DW'(s_tvalid), '0);
      tick();
      check_eq("single_tvalid_T2", DW'(s_tvalid), DW'(1));
      check_eq("single_tdata_T2", s_tdata, DW'(8'hA5));
      tick();
      check_eq("single_tvalid_T3", DW'(s_tvalid), '0);
      check_eq("single_cnt_T3", DW'(s_cnt), '0);

      // Streaming: 16 back-to-back beats.
      for (int i = 1; i <= 16; i++) push(DW'(i));
      first_rd = -1; first_beat = -1; last_beat = -1; rd_cnt = 0; nb = 0;
      for (int c = 0; c < 22; c++) begin
         tick();
         if (s_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = c;
         end
         if (s_beat) begin
            nb++;
            if (first_beat < 0) first_beat = c;
            last_beat = c;
         end
      end
      check_eq("stream_first_rd", DW'(first_rd), DW'(0));
      check_eq("stream_rd_count", DW'(rd_cnt), DW'(16));
      check_eq("stream_first_beat", DW'(first_beat), DW'(2));
      check_eq("stream_last_beat", DW'(last_beat), DW'(17));
      check_eq("stream_beats", DW'(nb), DW'(16));

      // Backpressure: only two words drawn while tready is low.
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 8; i++) push(DW'(i));
      rd_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (s_rd_en) rd_cnt++;
      end
      check_eq("bp_rd_count", DW'(rd_cnt), DW'(2));
      check_eq("bp_cnt", DW'(s_cnt), DW'(2));
      check_eq("bp_tvalid", DW'(s_tvalid), DW'(1));
      check_eq("bp_tdata", s_tdata, DW'(1));
      m_axis_tready = 1'b1;
      nb = 0;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (s_beat) nb++;
      end
      check_eq("bp_beats", DW'(nb), DW'(8));
      check_eq("bp_drained", DW'(exp_q.size()), '0);

      // Random gaps and backpressure over 1000 words.
      pushed = 0; rx = 0; cyc = 0;
      while (rx < 1000 && cyc < 20000) begin
         if (pushed < 1000 && $urandom_range(3) != 0) begin
            w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            push(w);
            pushed++;
         end
         gap = ($urandom_range(3) == 0);
         m_axis_tready = $urandom_range(1) == 1;
         tick();
         if (s_beat) rx++;
         cyc++;
      end
      gap = 1'b0;
      check_eq("rand_beats", DW'(rx), DW'(1000));
      check_eq("rand_leftover", DW'(exp_q.size()), '0);

      // Reset mid-stream with a word buffered and a read in flight.
      m_axis_tready = 1'b0;
      for (int i = 0; i < 4; i++) push(DW'(32'hC0DE_0000 + i));
      tick();
      tick();
      rst = 1'b1;
      fifo_q.delete();
      exp_q.delete();
      tick();
      check_eq("midrst_cnt_before", DW'(s_cnt), DW'(1));
      check_eq("midrst_rd_en", DW'(s_rd_en), '0);
      rst = 1'b0;
      data_out = '0;
      m_axis_tready = 1'b1;
      tick();
      check_eq("midrst_tvalid", DW'(s_tvalid), '0);
      check_eq("midrst_cnt", DW'(s_cnt), '0);
      check_eq("midrst_rd_after", DW'(s_rd_en), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
